serial_twos_complement_word: RTL and testbench
==============================================

SERIAL_TWOS_COMPLEMENT_WORD -- requirements
Module: serial_twos_complement_word

Interface
REQ-001 Parameter WIDTH, 8, word length in bits; SHALL be >= 2.
REQ-002 Parameter NEG_DEFAULT, 1, mode value used after reset until the first start.
REQ-003 Port clk  in  1  single clock; all state changes on its rising edge.
REQ-004 Port reset  in  1  synchronous, active-high reset.
REQ-005 Port start  in  1  one-cycle pulse that begins a new word.
REQ-006 Port mode  in  1  1 = negate (two's complement), 0 = pass-through; latched on start.
REQ-007 Port a  in  1  serial data bit, LSB first.
REQ-008 Port a_valid  in  1  a is valid this cycle.
REQ-009 Port out  out  1  Moore serial result bit, registered.
REQ-010 Port out_valid  out  1  out holds a new result bit this cycle.
REQ-011 Port word_out  out  WIDTH  assembled result word.
REQ-012 Port done  out  1  one-cycle pulse: word_out and ovf are valid.
REQ-013 Port ovf  out  1  negation overflow (input was the most negative value).
REQ-014 Port busy  out  1  high while a word is in progress.
REQ-015 Port state  out  2  current FSM state, for debug.

Function
REQ-016 The FSM SHALL have states IDLE=2'b00, COPY=2'b01, INV=2'b10 and DONE=2'b11.
REQ-017 On start in any state, the FSM SHALL go to COPY, latch mode, clear the bit counter and word_out, and clear ovf; a_valid in the start cycle SHALL be ignored.
REQ-018 In COPY with a_valid, the module SHALL register out=a; if a=1 it SHALL go to INV, otherwise it stays in COPY.
REQ-019 In INV with a_valid, the module SHALL register out = ~a when the latched mode=1, or out = a when mode=0.
REQ-020 out_valid SHALL be 1 exactly in the cycle after each accepted bit, giving a latency of 1 cycle.
REQ-021 Each result bit SHALL be written into word_out at the bit-counter index, LSB first.
REQ-022 Cycles with a_valid=0 SHALL stall the word: no state, counter or output change, and out_valid=0.
REQ-023 After WIDTH accepted bits, the FSM SHALL enter DONE.
  - done=1 for exactly one cycle, coincident with the out_valid of the final bit.
  - In that cycle the final bit is already included in word_out.
REQ-024 DONE SHALL go to IDLE on the next cycle unless start is asserted.
REQ-025 word_out and ovf SHALL hold their values until the next start or reset.
REQ-026 ovf SHALL be 1 iff mode=1 and the first 1 of the word arrives at the MSB position, i.e. the input is 1 followed by WIDTH-1 zeros.
REQ-027 For an all-zero input, the FSM SHALL stay in COPY, and the module SHALL give word_out=0 and ovf=0.
REQ-028 In IDLE and DONE, a_valid SHALL be ignored.
REQ-029 busy SHALL equal (state==COPY or state==INV).
REQ-030 The bit counter SHALL be $clog2(WIDTH) bits wide and SHALL never wrap mid-word.

Reset
REQ-031 When reset=1 at a clock edge, the module SHALL set state=IDLE, out=0, out_valid=0, word_out=0, done=0, ovf=0, busy=0, counter=0 and latched mode=NEG_DEFAULT.
REQ-032 Reset SHALL take priority over start and a_valid.
REQ-033 Reset mid-word SHALL discard the partial word, with no done pulse.

Structure
REQ-034 The state encodings SHALL be defined in the shared package serial_neg_pkg; nothing else belongs in that package.
REQ-035 The bit counter SHALL be the sub-module serial_bit_counter, parameterised by WIDTH, with inputs clear and inc and output last.

Verification
REQ-036 WIDTH=4, mode=1, a=0,1,1,0 (6) -> out=0,1,0,1; word_out=4'b1010; ovf=0; done once.
REQ-037 WIDTH=4, mode=1, a=0,0,0,1 (-8) -> word_out=4'b1000; ovf=1; state ends the word in COPY before DONE.
REQ-038 WIDTH=4, mode=0, a=0,1,1,0 -> word_out=4'b0110, ovf=0; and a=0,0,0,0 with mode=1 -> word_out=0, ovf=0.
REQ-039 WIDTH=8, mode=1, input 8'h01 with a_valid low on alternate cycles -> word_out=8'hFF; out_valid high only after valid bits; done after the 8th accepted bit.
REQ-040 Abort and reset -> both discard the partial word with no done pulse.
  - start after 2 bits, then feed 0,1,1,0 -> word_out=4'b1010.
  - reset after 2 bits -> all outputs return to zero.

Source files
------------

// File: rtl/serial_neg_pkg.sv
// State encodings shared by the serial two's-complement datapath.
package serial_neg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        COPY = 2'b01,
        INV  = 2'b10,
        DONE = 2'b11
    } state_t;

endpackage

// File: rtl/serial_bit_counter.sv
// Bit-position counter for one serial word; saturates on the last index.
module serial_bit_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       clear,
    input  logic                       inc,
    output logic [$clog2(WIDTH)-1:0]   count,
    output logic                       last
);

    localparam int unsigned CW = $clog2(WIDTH);

    assign last = (count == CW'(WIDTH - 1));

    // Holding at the last index keeps the counter from wrapping before the next clear.
    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (inc && !last) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/serial_twos_complement_word.sv
// Serial LSB-first two's-complement negator / pass-through with word assembly.
module serial_twos_complement_word
    import serial_neg_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter bit          NEG_DEFAULT = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic             a,
    input  logic             a_valid,
    output logic             out,
    output logic             out_valid,
    output logic [WIDTH-1:0] word_out,
    output logic             done,
    output logic             ovf,
    output logic             busy,
    output logic [1:0]       state
);

    localparam int unsigned CW = $clog2(WIDTH);

    state_t          state_q;
    logic            mode_q;
    logic [CW-1:0]   bit_idx;
    logic            last;
    logic            in_word;
    logic            accept;
    logic            res_bit;

    assign state   = state_q;
    assign in_word = (state_q == COPY) || (state_q == INV);
    assign accept  = !reset && !start && a_valid && in_word;
    // After the first 1 has passed, negation is a plain bit inversion.
    assign res_bit = (state_q == INV && mode_q) ? ~a : a;

    serial_bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk   (clk),
        .clear (reset | start),
        .inc   (accept),
        .count (bit_idx),
        .last  (last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            mode_q    <= NEG_DEFAULT;
            out       <= 1'b0;
            out_valid <= 1'b0;
            word_out  <= '0;
            done      <= 1'b0;
            ovf       <= 1'b0;
            busy      <= 1'b0;
        end else if (start) begin
            state_q   <= COPY;
            mode_q    <= mode;
            out_valid <= 1'b0;
            word_out  <= '0;
            done      <= 1'b0;
            ovf       <= 1'b0;
            busy      <= 1'b1;
        end else begin
            out_valid <= 1'b0;
            done      <= 1'b0;
            case (state_q)
                COPY, INV: begin
                    if (a_valid) begin
                        out               <= res_bit;
                        out_valid         <= 1'b1;
                        word_out[bit_idx] <= res_bit;
                        if (last) begin
                            state_q <= DONE;
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            // First 1 landing on the MSB means the most negative value.
                            ovf     <= mode_q && (state_q == COPY) && a;
                        end else if (state_q == COPY && a) begin
                            state_q <= INV;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_twos_complement_word.sv
// Randomized and directed check of serial_twos_complement_word at WIDTH 4 and 8.
module tb_serial_twos_complement_word;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, start, mode, a, a_valid;

    logic       out4, ov4, done4, ovf4, busy4;
    logic [3:0] word4;
    logic [1:0] st4;
    logic       out8, ov8, done8, ovf8, busy8;
    logic [7:0] word8;
    logic [1:0] st8;

    serial_twos_complement_word #(.WIDTH(4), .NEG_DEFAULT(1'b1)) dut4 (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .a(a), .a_valid(a_valid),
        .out(out4), .out_valid(ov4), .word_out(word4), .done(done4), .ovf(ovf4),
        .busy(busy4), .state(st4)
    );

    serial_twos_complement_word #(.WIDTH(8), .NEG_DEFAULT(1'b1)) dut8 (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .a(a), .a_valid(a_valid),
        .out(out8), .out_valid(ov8), .word_out(word8), .done(done8), .ovf(ovf8),
        .busy(busy8), .state(st8)
    );

    int total = 0;
    int bad   = 0;
    bit sel8  = 1'b0;

    logic       o_out, o_ov, o_done, o_ovf, o_busy;
    logic [7:0] o_word;
    logic [1:0] o_state;

    always_comb begin
        o_out   = sel8 ? out8  : out4;
        o_ov    = sel8 ? ov8   : ov4;
        o_done  = sel8 ? done8 : done4;
        o_ovf   = sel8 ? ovf8  : ovf4;
        o_busy  = sel8 ? busy8 : busy4;
        o_word  = sel8 ? word8 : {4'b0000, word4};
        o_state = sel8 ? st8   : st4;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Feed one bit (after optional stalls) and check the registered response.
    task automatic feed_bit(input logic b, input int stalls);
        for (int s = 0; s < stalls; s++) begin
            a_valid = 1'b0;
            a = 1'($urandom);
            @(negedge clk);
            chk("stall_out_valid", 32'(o_ov), 0);
            chk("stall_done", 32'(o_done), 0);
        end
        a = b;
        a_valid = 1'b1;
        @(negedge clk);
        a_valid = 1'b0;
    endtask

    task automatic start_word(input logic m);
        start = 1'b1; mode = m; a = 1'b1; a_valid = 1'b1;
        @(negedge clk);
        start = 1'b0; a_valid = 1'b0;
        chk("start_state", 32'(o_state), 1);
        chk("start_busy", 32'(o_busy), 1);
        chk("start_word", 32'(o_word), 0);
        chk("start_ovf", 32'(o_ovf), 0);
        chk("start_out_valid", 32'(o_ov), 0);
    endtask

    // stall_kind: 0 none, 1 one stall before every bit, 2 random stalls.
    task automatic run_word(input int w, input logic m, input logic [7:0] val_in, input int stall_kind);
        int modv, val, r, stalls;
        logic eovf;
        modv = 1 << w;
        val  = int'(val_in) % modv;
        r    = m ? (modv - val) % modv : val;
        eovf = m && (val == (modv >> 1));
        sel8 = (w == 8);
        start_word(m);
        for (int i = 0; i < w; i++) begin
            stalls = (stall_kind == 1) ? 1 : (stall_kind == 2) ? int'($urandom_range(2)) : 0;
            chk("pre_bit_state", 32'(o_state), ((val % (1 << i)) == 0) ? 1 : 2);
            feed_bit(1'((val >> i) & 1), stalls);
            chk("bit_out_valid", 32'(o_ov), 1);
            chk("bit_out", 32'(o_out), 32'((r >> i) & 1));
            chk("bit_done", 32'(o_done), (i == w - 1) ? 1 : 0);
        end
        chk("word_out", 32'(o_word), 32'(r));
        chk("word_ovf", 32'(o_ovf), 32'(eovf));
        chk("done_state", 32'(o_state), 3);
        chk("done_busy", 32'(o_busy), 0);
        a = 1'b1; a_valid = 1'b1;
        @(negedge clk);
        a_valid = 1'b0;
        chk("idle_state", 32'(o_state), 0);
        chk("idle_done", 32'(o_done), 0);
        chk("idle_out_valid", 32'(o_ov), 0);
        chk("hold_word", 32'(o_word), 32'(r));
        chk("hold_ovf", 32'(o_ovf), 32'(eovf));
        @(negedge clk);
        chk("idle_ignore_state", 32'(o_state), 0);
        chk("idle_ignore_word", 32'(o_word), 32'(r));
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_state"}, 32'(o_state), 0);
        chk({tag, "_out"}, 32'(o_out), 0);
        chk({tag, "_out_valid"}, 32'(o_ov), 0);
        chk({tag, "_word"}, 32'(o_word), 0);
        chk({tag, "_done"}, 32'(o_done), 0);
        chk({tag, "_ovf"}, 32'(o_ovf), 0);
        chk({tag, "_busy"}, 32'(o_busy), 0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; mode = 1'b0; a = 1'b0; a_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        sel8 = 1'b0;
        chk_reset_state("reset4");
        sel8 = 1'b1;
        chk_reset_state("reset8");

        // Directed words from the reference examples.
        run_word(4, 1'b1, 8'd6, 0);
        run_word(4, 1'b1, 8'd8, 0);
        run_word(4, 1'b0, 8'd6, 0);
        run_word(4, 1'b1, 8'd0, 0);
        run_word(8, 1'b1, 8'h01, 1);
        run_word(8, 1'b1, 8'h80, 2);
        run_word(8, 1'b0, 8'h80, 0);
        run_word(4, 1'b1, 8'd15, 2);

        // Abort: restart after two bits discards the partial word.
        sel8 = 1'b0;
        start_word(1'b1);
        feed_bit(1'b1, 0);
        chk("abort_done0", 32'(o_done), 0);
        feed_bit(1'b1, 0);
        chk("abort_done1", 32'(o_done), 0);
        run_word(4, 1'b1, 8'd6, 0);

        // Reset mid-word, asserted together with start to exercise priority.
        sel8 = 1'b0;
        start_word(1'b1);
        feed_bit(1'b1, 0);
        feed_bit(1'b0, 0);
        reset = 1'b1; start = 1'b1; a_valid = 1'b1;
        @(negedge clk);
        reset = 1'b0; start = 1'b0; a_valid = 1'b0;
        chk_reset_state("midreset");
        @(negedge clk);
        chk("midreset_nodone", 32'(o_done), 0);
        chk("midreset_idle", 32'(o_state), 0);

        // Randomized words against the arithmetic model.
        for (int n = 0; n < 24; n++) begin
            run_word(($urandom_range(1) == 1) ? 8 : 4, 1'($urandom), 8'($urandom), 2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
